// File: rtl/cr_huf_comp_hist_pp_pkg.sv
// Shared types and constants for the Huffman compressor histogram stage.
// Also supplies a default for `CREOLE_HC_SEQID_WIDTH when the project header is absent.
`ifndef CREOLE_HC_SEQID_WIDTH
`define CREOLE_HC_SEQID_WIDTH 8
`endif

package cr_huf_compPKG;

  typedef enum logic [0:0] {
    HIST_IDLE = 1'b0,
    HIST_SCAN = 1'b1
  } e_hist_state;

  localparam int HIST_FREQ_WIDTH = 15;
  localparam logic [HIST_FREQ_WIDTH-1:0] HIST_FREQ_MAX = '1;

  // Headroom for summing up to eight lanes of repeat counts.
  localparam int HIST_LANE_SUM_EXTRA = 3;

endpackage

// File: rtl/cr_huf_comp_hist_lane_sum.sv
// One histogram entry: sums the counts of every valid lane whose symbol matches ENTRY
// and adds the total to the current frequency, saturating at all-ones.
module cr_huf_comp_hist_lane_sum
  import cr_huf_compPKG::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int DAT_WIDTH      = 10,
  parameter int CNT_WIDTH      = 3,
  parameter int SYM_FREQ_WIDTH = 15,
  parameter int ENTRY          = 0
) (
  input  logic [NUM_LANES-1:0]           vld_i,
  input  logic [NUM_LANES*DAT_WIDTH-1:0] sym_i,
  input  logic [NUM_LANES*CNT_WIDTH-1:0] cnt_i,
  input  logic [SYM_FREQ_WIDTH-1:0]      cur_i,
  output logic [SYM_FREQ_WIDTH-1:0]      sum_o
);

  localparam int LSUM_W = CNT_WIDTH + HIST_LANE_SUM_EXTRA;
  localparam int EXT_W  = ((SYM_FREQ_WIDTH > LSUM_W) ? SYM_FREQ_WIDTH : LSUM_W) + 1;
  localparam logic [DAT_WIDTH-1:0] MY_SYM = DAT_WIDTH'(ENTRY);
  localparam logic [EXT_W-1:0]     SAT    = EXT_W'({SYM_FREQ_WIDTH{1'b1}});

  logic [LSUM_W-1:0] lane_total;
  logic [EXT_W-1:0]  wide;

  // NOTE: combinational blocks use blocking '=' and assign every output a default
  // first, so the accumulation reads top-down and no latch can be inferred.
  always_comb begin
    lane_total = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (vld_i[i] && (sym_i[i*DAT_WIDTH +: DAT_WIDTH] == MY_SYM)) begin
        lane_total = lane_total + LSUM_W'(cnt_i[i*CNT_WIDTH +: CNT_WIDTH]);
      end
    end
    wide  = EXT_W'(cur_i) + EXT_W'(lane_total);
    sum_o = (wide > SAT) ? '1 : wide[SYM_FREQ_WIDTH-1:0];
  end

endmodule

// File: rtl/cr_huf_comp_hist_pp.sv
// Ping-pong symbol histogram: accumulates sc beats into one bank while draining the other to ht.
// Optional feature: define CR_HUF_COMP_HIST_SKIP_ZERO_EN to emit only nonzero entries.
module cr_huf_comp_hist_pp
  import cr_huf_compPKG::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int DAT_WIDTH      = 10,
  parameter int CNT_WIDTH      = 3,
  parameter int SYM_FREQ_WIDTH = HIST_FREQ_WIDTH,
  parameter int NUM_SYM        = 576
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_LANES-1:0]                sc_hist_vld,
  input  logic [NUM_LANES*DAT_WIDTH-1:0]      sc_hist_sym,
  input  logic [NUM_LANES*CNT_WIDTH-1:0]      sc_hist_cnt,
  input  logic                                sc_hist_eob,
  input  logic [`CREOLE_HC_SEQID_WIDTH-1:0]   sc_hist_seq_id,
  output logic                                hist_sc_rd,
  output logic                                hist_ht_vld,
  output logic [DAT_WIDTH-1:0]                hist_ht_sym,
  output logic [SYM_FREQ_WIDTH-1:0]           hist_ht_freq,
  output logic                                hist_ht_last,
  output logic [`CREOLE_HC_SEQID_WIDTH-1:0]   hist_ht_seq_id,
  input  logic                                ht_hist_rdy
);

  localparam int SEQ_W = `CREOLE_HC_SEQID_WIDTH;

  typedef logic [SYM_FREQ_WIDTH-1:0] freq_t;

  freq_t bank0_q [NUM_SYM];
  freq_t bank1_q [NUM_SYM];
  freq_t bank0_d [NUM_SYM];
  freq_t bank1_d [NUM_SYM];
  freq_t acc_cur [NUM_SYM];
  freq_t acc_sum [NUM_SYM];
  freq_t acc_next[NUM_SYM];

  e_hist_state          state_q, state_d;
  logic                 acc_sel_q, acc_sel_d;
  logic                 pend_q, pend_d;
  logic [DAT_WIDTH-1:0] idx_q, idx_d;
  logic [SEQ_W-1:0]     pend_seq_q, pend_seq_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic [DAT_WIDTH-1:0] sym_q, sym_d;
  freq_t                freq_q, freq_d;

  logic                 acc_beat, eob_acc, drain_hs, swap;
  logic                 emit;
  logic [DAT_WIDTH-1:0] last_idx;
  freq_t                freq_nx;

  assign hist_sc_rd     = ~pend_q;
  assign hist_ht_vld    = vld_q;
  assign hist_ht_sym    = sym_q;
  assign hist_ht_freq   = freq_q;
  assign hist_ht_last   = last_q;
  assign hist_ht_seq_id = seq_q;

  assign acc_beat = hist_sc_rd && ((|sc_hist_vld) || sc_hist_eob);
  assign eob_acc  = acc_beat && sc_hist_eob;
  assign drain_hs = vld_q && ht_hist_rdy;

  // Per-entry match-and-sum against whichever bank is currently accumulating.
  for (genvar e = 0; e < NUM_SYM; e++) begin : g_entry
    assign acc_cur[e] = acc_sel_q ? bank1_q[e] : bank0_q[e];

    cr_huf_comp_hist_lane_sum #(
      .NUM_LANES      (NUM_LANES),
      .DAT_WIDTH      (DAT_WIDTH),
      .CNT_WIDTH      (CNT_WIDTH),
      .SYM_FREQ_WIDTH (SYM_FREQ_WIDTH),
      .ENTRY          (e)
    ) u_lane_sum (
      .vld_i (sc_hist_vld),
      .sym_i (sc_hist_sym),
      .cnt_i (sc_hist_cnt),
      .cur_i (acc_cur[e]),
      .sum_o (acc_sum[e])
    );

    assign acc_next[e] = acc_beat ? acc_sum[e] : acc_cur[e];
  end

  // Active bank takes the accumulated values; the drain bank clears each accepted entry.
  always_comb begin
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    if (acc_sel_q) bank1_d = acc_next;
    else           bank0_d = acc_next;
    if (drain_hs) begin
      if (acc_sel_q) bank0_d[idx_q] = '0;
      else           bank1_d[idx_q] = '0;
    end
  end

`ifdef CR_HUF_COMP_HIST_SKIP_ZERO_EN
  logic [DAT_WIDTH-1:0] last_nz_q, last_nz_d, nz_top;

  // Highest nonzero index of the bank about to be drained; 0 when the block is empty.
  always_comb begin
    nz_top = '0;
    for (int e = 0; e < NUM_SYM; e++) begin
      if (acc_next[e] != '0) nz_top = DAT_WIDTH'(e);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    acc_sel_d  = acc_sel_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    seq_d      = seq_q;
    swap       = 1'b0;
    pend_seq_d = eob_acc ? sc_hist_seq_id : pend_seq_q;

    case (state_q)
      HIST_IDLE: begin
        if (eob_acc) swap = 1'b1;
      end
      HIST_SCAN: begin
        if (drain_hs && last_q) begin
          if (pend_q || eob_acc) swap = 1'b1;
          else                   state_d = HIST_IDLE;
        end else begin
          if (eob_acc) pend_d = 1'b1;
          // A gap cycle (vld low) only happens while skipping a zero entry.
          if (drain_hs || !vld_q) idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = HIST_IDLE;
    endcase

    if (swap) begin
      state_d   = HIST_SCAN;
      acc_sel_d = ~acc_sel_q;
      idx_d     = '0;
      pend_d    = 1'b0;
      seq_d     = eob_acc ? sc_hist_seq_id : pend_seq_q;
    end
  end

`ifdef CR_HUF_COMP_HIST_SKIP_ZERO_EN
  assign last_nz_d = swap ? nz_top : last_nz_q;
`endif

  // Output beat is computed from next-state values so every port comes straight from a flop.
  always_comb begin
    freq_nx = acc_sel_d ? bank0_d[idx_d] : bank1_d[idx_d];
`ifdef CR_HUF_COMP_HIST_SKIP_ZERO_EN
    last_idx = last_nz_d;
    emit     = (freq_nx != '0) || (idx_d == last_nz_d);
`else
    last_idx = DAT_WIDTH'(NUM_SYM - 1);
    emit     = 1'b1;
`endif
    vld_d  = 1'b0;
    last_d = 1'b0;
    sym_d  = sym_q;
    freq_d = freq_q;
    if (state_d == HIST_SCAN) begin
      vld_d  = emit;
      last_d = emit && (idx_d == last_idx);
      sym_d  = idx_d;
      freq_d = freq_nx;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HIST_IDLE;
      acc_sel_q  <= 1'b0;
      pend_q     <= 1'b0;
      idx_q      <= '0;
      pend_seq_q <= '0;
      seq_q      <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      sym_q      <= '0;
      freq_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_sel_q  <= acc_sel_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      pend_seq_q <= pend_seq_d;
      seq_q      <= seq_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      sym_q      <= sym_d;
      freq_q     <= freq_d;
    end
  end

  // NOTE: the banks are flops rather than RAM and are cleared on reset, so a block
  // interrupted by reset cannot leak counts into the next histogram.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q <= '{default: '0};
      bank1_q <= '{default: '0};
    end else begin
      bank0_q <= bank0_d;
      bank1_q <= bank1_d;
    end
  end

`ifdef CR_HUF_COMP_HIST_SKIP_ZERO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_nz_q <= '0;
    else        last_nz_q <= last_nz_d;
  end
`endif

endmodule
